// File: rtl/envio_resposta_pkg.sv
// ---------------------------------------------------------------------------
// envio_resposta_pkg
// Shared definitions for the response-transmit stage:
//   - serializer state encodings (legacy 2-bit values)
//   - command-code constants shared with the sensor connection
//   - the response pair type (command byte + value byte)
//   - the CLKS_PER_BIT derivation from clock frequency and baud rate
// ---------------------------------------------------------------------------
package envio_resposta_pkg;

    // Serializer FSM encodings, kept at their historical values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Command codes published by the sensor connection.
    localparam logic [7:0] CMD_07 = 8'h07;
    localparam logic [7:0] CMD_1F = 8'h1F;
    localparam logic [7:0] CMD_TEMPERATURE = 8'h09;
    localparam logic [7:0] CMD_08 = 8'h08;
    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_ERROR = 8'h45;
    localparam logic [7:0] CMD_FF = 8'hFF;
    localparam logic [7:0] CMD_AB = 8'hAB;

    // One response as published by the sensor connection; the two bytes
    // always travel together.
    typedef struct packed {
        logic [7:0] command;
        logic [7:0] value;
    } resp_pair_t;

    // Cycles per serial bit for a given system clock and baud rate.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/envio_resposta_if.sv
// ---------------------------------------------------------------------------
// envio_resposta_if
// Bundles the sensor-side response handshake and the UART-side outputs.
//   dados_validos     data-ready strobe/level; rising edge = new response
//   response_command  command byte of the response
//   response_value    value byte of the response
//   tx                UART serial line, idle high
//   busy              a two-byte frame is being shifted
//   done              one-cycle pulse at the end of the second stop bit
//   overrun           one-cycle pulse when an unsent pending pair is lost
// master: the producer side (sensor connection / bench)
// slave : envio_resposta
// ---------------------------------------------------------------------------
interface envio_resposta_if;
    logic       dados_validos;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       tx;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output dados_validos, response_command, response_value,
        input  tx, busy, done, overrun
    );

    modport slave (
        input  dados_validos, response_command, response_value,
        output tx, busy, done, overrun
    );
endinterface

// File: rtl/envio_resposta_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Single-byte 8N1 serializer: start bit, 8 data bits LSB first, stop bit,
// each lasting CLKS_PER_BIT cycles.
//   clock, reset_n  system clock, asynchronous active-low reset
//   start           load data and begin a byte; honoured when idle or in
//                   the last cycle of the stop bit (back-to-back bytes)
//   data            byte to send, sampled with start
//   tx              serial line (registered, idle high)
//   busy            registered, high from start bit to end of stop bit
//   done            registered, high during the last cycle of the stop bit
//   done_next       combinational, high the cycle before done rises
// ---------------------------------------------------------------------------
module uart_tx_byte
    import envio_resposta_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       done_next
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // done is registered from this, so it lands exactly on the last stop
    // cycle; that is the cycle in which the next byte may be handed over.
    assign done_next = (state == ST_STOP) && (baud_cnt == CNT_PRE);

    // NOTE: every register here, data path included, takes the async reset
    // so the line is idle and no stale byte survives a mid-frame reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge values of the state registers.
            done <= done_next;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        state    <= ST_START;
                        tx       <= 1'b0;
                        shreg    <= data;
                        baud_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin // ST_STOP
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (start) begin
                            // Next byte follows with no idle gap.
                            state <= ST_START;
                            tx    <= 1'b0;
                            shreg <= data;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/envio_resposta.sv
// ---------------------------------------------------------------------------
// envio_resposta
// Sends each (command, value) response from the sensor connection to the
// host as two back-to-back 8N1 frames, command first. A one-deep pending
// buffer absorbs a response that arrives while a frame is in flight.
//   clock    system clock, all logic on posedge
//   reset_n  asynchronous active-low reset; discards frame and pending pair
//   bus      envio_resposta_if.slave:
//              in : dados_validos, response_command, response_value
//              out: tx, busy, done, overrun (all registered)
// Parameters: CLK_FREQ, BAUD, CLKS_PER_BIT (>= 2, overridable for sim).
// ---------------------------------------------------------------------------
module envio_resposta
    import envio_resposta_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic              clock,
    input  logic              reset_n,
    envio_resposta_if.slave   bus
);

    logic       dv_q;
    logic       new_resp;
    resp_pair_t incoming;
    resp_pair_t cur;
    resp_pair_t pend;
    logic       pend_valid;
    logic       byte_sel;     // 0: command byte on the line, 1: value byte
    logic       busy_q;
    logic       done_q;
    logic       overrun_q;

    logic       ser_start;
    logic [7:0] ser_data;
    logic       ser_tx;
    logic       ser_busy;
    logic       ser_done;
    logic       ser_done_next;

    logic       idle_start;
    logic       byte_handoff;
    logic       frame_end;

    assign incoming = {bus.response_command, bus.response_value};

    // dv_q resets high so a level already present at reset release is not
    // mistaken for a new response.
    assign new_resp = bus.dados_validos & ~dv_q;

    // ser_done marks the last stop-bit cycle of the serializer: the point
    // where the next byte (or the next frame) is handed over.
    assign idle_start   = ~busy_q & ~ser_busy & new_resp;
    assign byte_handoff = busy_q & ser_done & ~byte_sel;
    assign frame_end    = busy_q & ser_done & byte_sel;

    always_comb begin
        // NOTE: defaults first, so no path through this block infers a latch.
        ser_start = 1'b0;
        ser_data  = cur.command;
        if (idle_start) begin
            ser_start = 1'b1;
            ser_data  = incoming.command;
        end else if (byte_handoff) begin
            ser_start = 1'b1;
            ser_data  = cur.value;
        end else if (frame_end) begin
            if (pend_valid) begin
                ser_start = 1'b1;
                ser_data  = pend.command;
            end else if (new_resp) begin
                ser_start = 1'b1;
                ser_data  = incoming.command;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dv_q       <= 1'b1;
            cur        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            byte_sel   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dv_q      <= bus.dados_validos;
            done_q    <= ser_done_next & byte_sel;
            overrun_q <= 1'b0;

            if (idle_start) begin
                busy_q   <= 1'b1;
                cur      <= incoming;
                byte_sel <= 1'b0;
            end else if (byte_handoff) begin
                byte_sel <= 1'b1;
            end else if (frame_end) begin
                byte_sel <= 1'b0;
                if (pend_valid) begin
                    // Pending pair goes out next; a response arriving on this
                    // same cycle takes its place without counting as overrun.
                    cur        <= pend;
                    pend_valid <= new_resp;
                    if (new_resp) begin
                        pend <= incoming;
                    end
                end else if (new_resp) begin
                    cur <= incoming;
                end else begin
                    busy_q <= 1'b0;
                end
            end

            // Mid-frame arrivals land in the pending slot; replacing an
            // unsent pair is the only overrun condition.
            if (busy_q && new_resp && !frame_end) begin
                pend       <= incoming;
                pend_valid <= 1'b1;
                overrun_q  <= pend_valid;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (ser_start),
        .data      (ser_data),
        .tx        (ser_tx),
        .busy      (ser_busy),
        .done      (ser_done),
        .done_next (ser_done_next)
    );

    assign bus.tx      = ser_tx;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule
